// File: rtl/spi_slave_sync.sv
// Fully synchronous SPI slave: SCLK/MOSI/SS are oversampled in the clk domain.
// Provides a valid/ready TX handshake, an RX strobe and a scanned row/column history display.
module spi_slave_sync #(
    parameter int              WIDTH    = 8,
    parameter int              CPOL     = 0,
    parameter int              CPHA     = 0,
    parameter int              DEPTH    = 3,
    parameter int              COL_W    = 4,
    parameter int              SCAN_DIV = 150000,
    parameter logic [WIDTH-1:0] FILL    = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SCLK,
    input  logic             MOSI,
    input  logic             SS,
    output logic             MISO,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             underrun,
    output logic             abort,
    output logic [WIDTH-1:0] leds,
    output logic [DEPTH-1:0] rows,
    output logic [COL_W-1:0] cols
);
    localparam int                CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam int                IDX_W       = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DEPTH - 1);
    localparam int                SCAN_W      = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_RELOAD = SCAN_W'(SCAN_DIV - 1);
    localparam logic              IDLE_SCLK   = (CPOL != 0);
    localparam logic              SAMPLE_TRAIL = (CPHA != 0);

    logic [2:0]         sclk_s;
    logic [2:0]         ss_s;
    logic [1:0]         mosi_s;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WIDTH-2:0]   shift_rx;
    logic [WIDTH-2:0]   shift_tx;
    logic [COL_W-1:0]   history [DEPTH];
    logic [IDX_W-1:0]   scan_idx;
    logic [SCAN_W-1:0]  scan_cnt;

    logic lead_edge, trail_edge, selected, sample_hit, shift_hit;
    logic ss_fall, ss_rise, word_done, load;
    logic [WIDTH-1:0] rx_word, load_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= {3{IDLE_SCLK}};
            ss_s   <= 3'b111;
            mosi_s <= 2'b00;
        end else begin
            sclk_s <= {sclk_s[1:0], SCLK};
            ss_s   <= {ss_s[1:0], SS};
            mosi_s <= {mosi_s[0], MOSI};
        end
    end

    // Edges are accepted while the previous synced SS was low, so a word completing
    // in the same cycle that SS rises is still delivered.
    always_comb begin
        lead_edge  = (sclk_s[2] == IDLE_SCLK) && (sclk_s[1] != IDLE_SCLK);
        trail_edge = (sclk_s[2] != IDLE_SCLK) && (sclk_s[1] == IDLE_SCLK);
        selected   = ~ss_s[2];
        ss_fall    = ss_s[2] & ~ss_s[1];
        ss_rise    = ~ss_s[2] & ss_s[1];
        sample_hit = selected && (SAMPLE_TRAIL ? trail_edge : lead_edge);
        shift_hit  = selected && (SAMPLE_TRAIL ? lead_edge : trail_edge) && (bit_cnt != '0);
        rx_word    = {shift_rx, mosi_s[1]};
        word_done  = sample_hit && (bit_cnt == LAST_BIT);
        load       = ~ss_rise && (ss_fall || word_done);
        load_word  = tx_valid ? tx_data : FILL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            MISO     <= 1'b0;
            miso_oe  <= 1'b0;
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
            rx_data  <= '0;
            leds     <= '0;
            bit_cnt  <= '0;
            shift_rx <= '0;
            shift_tx <= '0;
            for (int i = 0; i < DEPTH; i++) history[i] <= '0;
        end else begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            underrun <= 1'b0;
            abort    <= 1'b0;
            if (sample_hit) begin
                shift_rx <= rx_word[WIDTH-2:0];
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end
            if (word_done) begin
                bit_cnt  <= '0;
                rx_data  <= rx_word;
                leds     <= rx_word;
                rx_valid <= 1'b1;
                for (int i = 0; i < DEPTH - 1; i++) history[i] <= history[i+1];
                history[DEPTH-1] <= rx_word[COL_W-1:0];
            end
            if (shift_hit) begin
                MISO     <= shift_tx[WIDTH-2];
                shift_tx <= {shift_tx[WIDTH-3:0], 1'b0};
            end
            if (ss_rise) begin
                abort   <= ~word_done && ((bit_cnt != '0) || sample_hit);
                bit_cnt <= '0;
                miso_oe <= 1'b0;
                MISO    <= 1'b0;
            end else if (load) begin
                shift_tx <= load_word[WIDTH-2:0];
                MISO     <= load_word[WIDTH-1];
                miso_oe  <= 1'b1;
                tx_ready <= tx_valid;
                underrun <= ~tx_valid;
            end
        end
    end

    // Row scan: one-cold row select, columns show the inverted low bits of that entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows     <= '1;
            cols     <= '0;
            scan_idx <= '0;
            scan_cnt <= '0;
        end else if (scan_cnt == '0) begin
            scan_cnt <= SCAN_RELOAD;
            rows     <= ~(DEPTH'(1) << scan_idx);
            cols     <= ~history[scan_idx];
            scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt - SCAN_W'(1);
        end
    end
endmodule
